// File: rtl/qtable_pkg.sv
// qtable_pkg: shared packet-type codes, status codes and FSM states for the Q-table update engine.
package qtable_pkg;
  localparam logic [2:0] PKT_HB   = 3'd1;
  localparam logic [2:0] PKT_CHE  = 3'd2;
  localparam logic [2:0] PKT_CHT  = 3'd3;
  localparam logic [2:0] PKT_DATA = 3'd5;
  localparam int         NULL_ID  = 0;
  typedef enum logic [1:0] {
    ST_UPDATED  = 2'b00,
    ST_INSERTED = 2'b01,
    ST_FULL     = 2'b10,
    ST_IGNORED  = 2'b11
  } status_t;
  typedef enum logic [2:0] {
    IDLE, NB_SCAN, NB_WR, CH_SCAN, CH_WR, BEST, DONE
  } state_t;
endpackage

// File: rtl/qtable_reg_bank.sv
// qtable_reg_bank: register array with one synchronous write port; the whole array is exposed for async reads.
module qtable_reg_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        we,
  input  logic [AW-1:0]               waddr,
  input  logic [WIDTH-1:0]            wdata,
  output logic [DEPTH-1:0][WIDTH-1:0] mem
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) mem_q <= '0;
    else       mem_q <= mem_d;
  assign mem = mem_q;
endmodule

// File: rtl/qtable_update_param.sv
// qtable_update_param: per-packet neighbour-table / known-CH update with a max-Q next-hop rescan.
module qtable_update_param
  import qtable_pkg::*;
#(
  parameter int         WORD_WIDTH  = 16,
  parameter int         NB_DEPTH    = 16,
  parameter int         CH_DEPTH    = 8,
  parameter logic [7:0] UPDATE_MASK = 8'b0010_1110
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            en,
  input  logic                            clr,
  input  logic [WORD_WIDTH-1:0]           f_source_id,
  input  logic [WORD_WIDTH-1:0]           f_source_hops,
  input  logic [WORD_WIDTH-1:0]           f_cluster_id,
  input  logic [WORD_WIDTH-1:0]           f_energy_left,
  input  logic [WORD_WIDTH-1:0]           f_q_value,
  input  logic [WORD_WIDTH-1:0]           f_known_ch,
  input  logic [2:0]                      f_packet_type,
  input  logic [$clog2(NB_DEPTH)-1:0]     rd_idx,
  output logic [WORD_WIDTH-1:0]           rd_id,
  output logic [WORD_WIDTH-1:0]           rd_hops,
  output logic [WORD_WIDTH-1:0]           rd_cluster,
  output logic [WORD_WIDTH-1:0]           rd_energy,
  output logic [WORD_WIDTH-1:0]           rd_q,
  output logic [$clog2(NB_DEPTH+1)-1:0]   neighbor_count,
  output logic [$clog2(CH_DEPTH+1)-1:0]   known_ch_count,
  output logic                            best_valid,
  output logic [WORD_WIDTH-1:0]           best_id,
  output logic [WORD_WIDTH-1:0]           best_q,
  output logic [1:0]                      status,
  output logic                            busy,
  output logic                            done
);
  localparam int W   = WORD_WIDTH;
  localparam int EW  = 5 * W;
  localparam int IW  = $clog2(NB_DEPTH);
  localparam int NCW = $clog2(NB_DEPTH + 1);
  localparam int CIW = CH_DEPTH > 1 ? $clog2(CH_DEPTH) : 1;
  localparam int CCW = $clog2(CH_DEPTH + 1);
  logic [NB_DEPTH-1:0][EW-1:0] nb_mem;
  logic [CH_DEPTH-1:0][W-1:0]  ch_mem;
  state_t              state_q, state_d;
  status_t             status_q, status_d;
  logic [EW-1:0]       pkt_q, pkt_d;
  logic [W-1:0]        kch_q, kch_d;
  logic [NCW-1:0]      nb_i_q, nb_i_d, nb_cnt_q, nb_cnt_d;
  logic [CCW-1:0]      ch_i_q, ch_i_d, ch_cnt_q, ch_cnt_d;
  logic                ins_q, ins_d, ch_new_q, ch_new_d;
  logic [W-1:0]        cid_q, cid_d, cq_q, cq_d;
  logic                best_valid_q, best_valid_d, busy_q, busy_d, done_q, done_d;
  logic [W-1:0]        best_id_q, best_id_d, best_q_q, best_q_d;
  logic                nb_we, ch_we, nb_full, take;
  logic [IW-1:0]       nb_sel;
  logic [CIW-1:0]      ch_sel;
  logic [W-1:0]        nb_id, nb_qv, ch_ent;
  logic [EW-1:0]       nb_rd;
  // Packed entry layout: {id, hops, cluster, energy, q}; the latched packet uses the same layout.
  qtable_reg_bank #(.WIDTH(EW), .DEPTH(NB_DEPTH)) u_nb (
    .clk(clk), .nrst(nrst), .we(nb_we), .waddr(nb_sel), .wdata(pkt_q), .mem(nb_mem)
  );
  qtable_reg_bank #(.WIDTH(W), .DEPTH(CH_DEPTH)) u_ch (
    .clk(clk), .nrst(nrst), .we(ch_we), .waddr(ch_sel), .wdata(kch_q), .mem(ch_mem)
  );
  assign nb_sel  = nb_i_q[IW-1:0];
  assign ch_sel  = ch_we ? ch_cnt_q[CIW-1:0] : ch_i_q[CIW-1:0];
  assign nb_id   = nb_mem[nb_sel][EW-1 -: W];
  assign nb_qv   = nb_mem[nb_sel][W-1:0];
  assign ch_ent  = ch_mem[ch_i_q[CIW-1:0]];
  assign nb_full = nb_cnt_q == NCW'(NB_DEPTH);
  assign take    = nb_i_q == '0 || nb_qv > cq_q;
  assign nb_rd   = {1'b0, rd_idx} < (IW + 1)'(NB_DEPTH) ? nb_mem[rd_idx] : '0;
  assign {rd_id, rd_hops, rd_cluster, rd_energy, rd_q} = nb_rd;
  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    pkt_d        = pkt_q;
    kch_d        = kch_q;
    nb_i_d       = nb_i_q;
    nb_cnt_d     = nb_cnt_q;
    ch_i_d       = ch_i_q;
    ch_cnt_d     = ch_cnt_q;
    ins_d        = ins_q;
    ch_new_d     = ch_new_q;
    cid_d        = cid_q;
    cq_d         = cq_q;
    best_valid_d = best_valid_q;
    best_id_d    = best_id_q;
    best_q_d     = best_q_q;
    nb_we        = 1'b0;
    ch_we        = 1'b0;
    case (state_q)
      IDLE:
        if (en) begin
          pkt_d = {f_source_id, f_source_hops, f_cluster_id, f_energy_left, f_q_value};
          kch_d = f_known_ch;
          if (!UPDATE_MASK[f_packet_type] || f_source_id == W'(NULL_ID)) begin
            state_d  = DONE;
            status_d = ST_IGNORED;
          end else begin
            state_d = NB_SCAN;
            nb_i_d  = '0;
          end
        end else if (clr) begin
          nb_cnt_d     = '0;
          ch_cnt_d     = '0;
          best_valid_d = 1'b0;
          best_id_d    = '0;
          best_q_d     = '0;
        end
      NB_SCAN:
        if (nb_i_q == nb_cnt_q) begin
          ins_d   = 1'b1;
          state_d = NB_WR;
        end else if (nb_id == pkt_q[EW-1 -: W]) begin
          ins_d   = 1'b0;
          state_d = NB_WR;
        end else nb_i_d = nb_i_q + 1'b1;
      NB_WR: begin
        nb_we    = !ins_q || !nb_full;
        nb_cnt_d = ins_q && !nb_full ? nb_cnt_q + 1'b1 : nb_cnt_q;
        status_d = !ins_q ? ST_UPDATED : nb_full ? ST_FULL : ST_INSERTED;
        ch_i_d   = '0;
        state_d  = CH_SCAN;
      end
      CH_SCAN:
        if (ch_i_q == ch_cnt_q) begin
          ch_new_d = 1'b1;
          state_d  = CH_WR;
        end else if (ch_ent == kch_q) begin
          ch_new_d = 1'b0;
          state_d  = CH_WR;
        end else ch_i_d = ch_i_q + 1'b1;
      CH_WR: begin
        ch_we    = ch_new_q && kch_q != W'(NULL_ID) && ch_cnt_q != CCW'(CH_DEPTH);
        ch_cnt_d = ch_we ? ch_cnt_q + 1'b1 : ch_cnt_q;
        nb_i_d   = '0;
        state_d  = BEST;
      end
      BEST: begin
        // Strict '>' keeps the earliest entry on equal Q.
        cid_d = take ? nb_id : cid_q;
        cq_d  = take ? nb_qv : cq_q;
        if (nb_i_q + 1'b1 >= nb_cnt_q) begin
          best_valid_d = nb_cnt_q != '0;
          best_id_d    = nb_cnt_q != '0 ? cid_d : '0;
          best_q_d     = nb_cnt_q != '0 ? cq_d : '0;
          state_d      = DONE;
        end else nb_i_d = nb_i_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q      <= IDLE;
      status_q     <= ST_UPDATED;
      pkt_q        <= '0;
      kch_q        <= '0;
      nb_i_q       <= '0;
      nb_cnt_q     <= '0;
      ch_i_q       <= '0;
      ch_cnt_q     <= '0;
      ins_q        <= 1'b0;
      ch_new_q     <= 1'b0;
      cid_q        <= '0;
      cq_q         <= '0;
      best_valid_q <= 1'b0;
      best_id_q    <= '0;
      best_q_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      pkt_q        <= pkt_d;
      kch_q        <= kch_d;
      nb_i_q       <= nb_i_d;
      nb_cnt_q     <= nb_cnt_d;
      ch_i_q       <= ch_i_d;
      ch_cnt_q     <= ch_cnt_d;
      ins_q        <= ins_d;
      ch_new_q     <= ch_new_d;
      cid_q        <= cid_d;
      cq_q         <= cq_d;
      best_valid_q <= best_valid_d;
      best_id_q    <= best_id_d;
      best_q_q     <= best_q_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  assign neighbor_count = nb_cnt_q;
  assign known_ch_count = ch_cnt_q;
  assign best_valid     = best_valid_q;
  assign best_id        = best_id_q;
  assign best_q         = best_q_q;
  assign status         = status_q;
  assign busy           = busy_q;
  assign done           = done_q;
endmodule

// File: tb/tb_qtable_update_param.sv
// tb_qtable_update_param: directed bench for a 4-entry neighbour table and 2-entry CH list.
module tb_qtable_update_param;
  logic        clk = 1'b0, nrst = 1'b0, en = 1'b0, clr = 1'b0;
  logic [15:0] f_source_id = '0, f_source_hops = '0, f_cluster_id = '0;
  logic [15:0] f_energy_left = '0, f_q_value = '0, f_known_ch = '0;
  logic [2:0]  f_packet_type = '0;
  logic [1:0]  rd_idx = '0;
  logic [15:0] rd_id, rd_hops, rd_cluster, rd_energy, rd_q, best_id, best_q;
  logic [2:0]  neighbor_count;
  logic [1:0]  known_ch_count, status;
  logic        best_valid, busy, done;
  int          tests = 0, fails = 0, lat, dones, found;
  always #5 clk = ~clk;
  qtable_update_param #(.WORD_WIDTH(16), .NB_DEPTH(4), .CH_DEPTH(2), .UPDATE_MASK(8'b0010_1110)) dut (
    .clk(clk), .nrst(nrst), .en(en), .clr(clr),
    .f_source_id(f_source_id), .f_source_hops(f_source_hops), .f_cluster_id(f_cluster_id),
    .f_energy_left(f_energy_left), .f_q_value(f_q_value), .f_known_ch(f_known_ch),
    .f_packet_type(f_packet_type), .rd_idx(rd_idx),
    .rd_id(rd_id), .rd_hops(rd_hops), .rd_cluster(rd_cluster), .rd_energy(rd_energy), .rd_q(rd_q),
    .neighbor_count(neighbor_count), .known_ch_count(known_ch_count),
    .best_valid(best_valid), .best_id(best_id), .best_q(best_q),
    .status(status), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [15:0] id, hops, cl, e, q, input logic [2:0] ty, input logic [15:0] kch);
    @(negedge clk);
    {f_source_id, f_source_hops, f_cluster_id, f_energy_left, f_q_value} = {id, hops, cl, e, q};
    f_packet_type = ty;
    f_known_ch    = kch;
    en            = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    {f_source_id, f_source_hops, f_cluster_id, f_energy_left, f_q_value, f_known_ch} = {6{16'hDEAD}};
    f_packet_type = 3'd0;
  endtask
  // Edges after the start edge until done is seen; a missing pulse shows up as 60.
  task automatic run(input logic [15:0] id, hops, cl, e, q, input logic [2:0] ty, input logic [15:0] kch,
                     output int n);
    drive(id, hops, cl, e, q, ty, kch);
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
  endtask
  task automatic ent(input logic [1:0] i, input logic [15:0] id, cl, q);
    rd_idx = i;
    #1;
    chk("rd_id", rd_id, id);
    chk("rd_cluster", rd_cluster, cl);
    chk("rd_q", rd_q, q);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_nbc", neighbor_count, 0);
    chk("rst_chc", known_ch_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_status", status, 0);
    chk("rst_best", {best_valid, best_id, best_q}, 0);
    chk("rst_rd_id", rd_id, 0);
    @(negedge clk) nrst = 1'b1;
    run(16'd1, 16'd2, 16'd2, 16'h8000, 16'h3000, 3'b101, 16'd15, lat);
    chk("t1_lat", lat, 5);
    chk("t1_status", status, 2'b01);
    chk("t1_nbc", neighbor_count, 1);
    chk("t1_chc", known_ch_count, 1);
    chk("t1_best", {best_valid, best_id, best_q}, {1'b1, 16'd1, 16'h3000});
    ent(2'd0, 16'd1, 16'd2, 16'h3000);
    chk("t1_hops", rd_hops, 16'd2);
    chk("t1_energy", rd_energy, 16'h8000);
    run(16'd1, 16'd2, 16'd3, 16'h1800, 16'hB800, 3'b101, 16'd15, lat);
    chk("t2_lat", lat, 5);
    chk("t2_status", status, 2'b00);
    chk("t2_nbc", neighbor_count, 1);
    chk("t2_chc", known_ch_count, 1);
    ent(2'd0, 16'd1, 16'd3, 16'hB800);
    chk("t2_best_q", best_q, 16'hB800);
    // id 2 scans past entry 0; known_ch 0 scans the one-entry CH list without writing.
    run(16'd2, 16'd1, 16'd4, 16'h4000, 16'h1000, 3'd1, 16'd0, lat);
    chk("t3_lat_id2", lat, 8);
    chk("t3_status_id2", status, 2'b01);
    chk("t3_nbc_id2", neighbor_count, 2);
    chk("t3_chc_zero", known_ch_count, 1);
    run(16'd3, 16'd1, 16'd4, 16'h4000, 16'h1000, 3'd2, 16'd7, lat);
    chk("t3_nbc_id3", neighbor_count, 3);
    chk("t3_chc_7", known_ch_count, 2);
    run(16'd4, 16'd1, 16'd4, 16'h4000, 16'h1000, 3'd3, 16'd9, lat);
    chk("t3_nbc_id4", neighbor_count, 4);
    chk("t3_chc_full", known_ch_count, 2);
    chk("t3_best_id", best_id, 16'd1);
    run(16'd5, 16'd1, 16'd4, 16'h4000, 16'h1000, 3'd5, 16'd0, lat);
    chk("t3_lat_full", lat, 14);
    chk("t3_status_full", status, 2'b10);
    chk("t3_nbc_full", neighbor_count, 4);
    found = 0;
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      if (rd_id == 16'd5) found++;
    end
    chk("t3_id5_absent", found, 0);
    ent(2'd3, 16'd4, 16'd4, 16'h1000);
    run(16'd2, 16'd1, 16'd4, 16'h4000, 16'hC000, 3'd1, 16'd0, lat);
    chk("t4_best_id2", best_id, 16'd2);
    run(16'd3, 16'd1, 16'd4, 16'h4000, 16'hC000, 3'd1, 16'd0, lat);
    chk("t4_status", status, 2'b00);
    chk("t4_tie_id", best_id, 16'd2);
    chk("t4_tie_q", best_q, 16'hC000);
    run(16'd6, 16'd1, 16'd1, 16'h1, 16'hFFFF, 3'b000, 16'd11, lat);
    chk("t5_lat_ign", lat, 0);
    chk("t5_status_ign", status, 2'b11);
    chk("t5_nbc", neighbor_count, 4);
    chk("t5_chc", known_ch_count, 2);
    chk("t5_best", best_id, 16'd2);
    // Second en with a fresh id while busy must be dropped, not queued.
    drive(16'd4, 16'd1, 16'd1, 16'h1, 16'h1000, 3'd1, 16'd0);
    f_source_id   = 16'd7;
    f_packet_type = 3'd1;
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    dones = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("t5_one_done", dones, 1);
    chk("t5_busy_status", status, 2'b00);
    chk("t5_busy_nbc", neighbor_count, 4);
    drive(16'd8, 16'd1, 16'd1, 16'h1, 16'h2000, 3'd5, 16'd0);
    @(posedge clk);
    #1;
    chk("t6_busy_mid", busy, 1);
    nrst = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_nbc", neighbor_count, 0);
    chk("t6_rst_chc", known_ch_count, 0);
    dones = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("t6_no_done", dones, 0);
    chk("t6_rd_cleared", rd_id, 0);
    @(negedge clk) nrst = 1'b1;
    run(16'd1, 16'd2, 16'd2, 16'h8000, 16'h3000, 3'b101, 16'd15, lat);
    chk("t6_reinsert_nbc", neighbor_count, 1);
    chk("t6_reinsert_bv", best_valid, 1);
    @(negedge clk) clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("t6_clr_nbc", neighbor_count, 0);
    chk("t6_clr_chc", known_ch_count, 0);
    chk("t6_clr_best", {best_valid, best_id, best_q}, 0);
    chk("t6_clr_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
